// File: rtl/alu_share_ctrl_pkg.sv
// Shared constants for the two-requester ALU sharing controller:
// FSM state encoding, opcodes and datapath widths.
package alu_share_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_MUL = 2'd1;
    localparam logic [1:0] OP_SUB = 2'd2;
    localparam logic [1:0] OP_AND = 2'd3;

    localparam int OPND_W = 4;
    localparam int RES_W  = 8;
    localparam int OP_W   = 2;
    localparam int CNT_W  = 3;

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-input round-robin arbiter. On a tie the requester not granted last wins;
// the pointer moves only when a grant is actually issued.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    logic       r_last;
    logic [1:0] w_gnt;

    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    // Reset value 1 lets requester 0 win the first tie.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_last <= 1'b1;
        else if (|w_gnt)
            r_last <= w_gnt[1];
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters: arbitrate in IDLE, hold
// operands for ALU_LAT cycles in EXEC, strobe the result for one cycle in RESP.
module alu_share_ctrl
    import alu_share_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0_valid,
    input  logic [OPND_W-1:0] i_req0_a,
    input  logic [OPND_W-1:0] i_req0_b,
    input  logic [OP_W-1:0]   i_req0_op,
    output logic              o_req0_ready,
    input  logic              i_req1_valid,
    input  logic [OPND_W-1:0] i_req1_a,
    input  logic [OPND_W-1:0] i_req1_b,
    input  logic [OP_W-1:0]   i_req1_op,
    output logic              o_req1_ready,
    output logic [OPND_W-1:0] o_alu_a,
    output logic [OPND_W-1:0] o_alu_b,
    output logic [OP_W-1:0]   o_alu_op,
    input  logic [RES_W-1:0]  i_alu_out,
    output logic              o_rsp0_valid,
    output logic              o_rsp1_valid,
    output logic [RES_W-1:0]  o_rsp_data,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(ALU_LAT);

    state_e             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [OPND_W-1:0]  r_a, r_b;
    logic [OP_W-1:0]    r_op;
    logic               r_sel;
    logic [RES_W-1:0]   r_rsp_data;
    logic [1:0]         w_gnt;
    logic               w_arb_en;
    logic               w_accept;

    assign w_arb_en = (r_state == ST_IDLE) && !i_rst;
    assign w_accept = |w_gnt;

    rr_arb2 u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_en  (w_arb_en),
        .i_req ({i_req1_valid, i_req0_valid}),
        .o_gnt (w_gnt)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: if (r_cnt <= 3'd1) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_sel      <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_accept) begin
                r_a   <= w_gnt[1] ? i_req1_a  : i_req0_a;
                r_b   <= w_gnt[1] ? i_req1_b  : i_req0_b;
                r_op  <= w_gnt[1] ? i_req1_op : i_req0_op;
                r_sel <= w_gnt[1];
                r_cnt <= LAT_INIT;
            end else if (r_state == ST_EXEC && r_cnt != '0) begin
                r_cnt <= r_cnt - 3'd1;
            end
            if (r_state == ST_RESP)
                r_rsp_data <= i_alu_out;
        end
    end

    // A registered ALU presents its result on the last EXEC edge itself, so the
    // result is forwarded during RESP and latched there for holding afterwards.
    always_comb begin
        o_busy       = (r_state != ST_IDLE);
        o_rsp0_valid = (r_state == ST_RESP) && !r_sel;
        o_rsp1_valid = (r_state == ST_RESP) &&  r_sel;
        o_rsp_data   = (r_state == ST_RESP) ? i_alu_out : r_rsp_data;
        o_req0_ready = w_gnt[0];
        o_req1_ready = w_gnt[1];
        o_alu_a      = r_a;
        o_alu_b      = r_b;
        o_alu_op     = r_op;
    end

endmodule

// File: doc/alu_share_ctrl.md
ALU_SHARE_CTRL -- requirements
Module: alu_share_ctrl

Interface
REQ-001 Parameter: ALU_LAT, default 1, number of clock edges from stable ALU operands to valid alu_out (legal range 1..7).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_a, req0_b  input  4 each  requester 0 operands.
REQ-006 req0_op  input  2  requester 0 opcode: 0 add, 1 multiply, 2 subtract, 3 bitwise AND.
REQ-007 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-008 req1_valid, req1_a, req1_b, req1_op, req1_ready: same widths and meaning for requester 1.
REQ-009 alu_a, alu_b  output  4 each  operands to the shared ALU.
REQ-010 alu_op  output  2  opcode to the shared ALU.
REQ-011 alu_out  input  8  shared ALU result.
REQ-012 rsp0_valid, rsp1_valid  output  1 each  one-cycle result strobe to requester 0/1.
REQ-013 rsp_data  output  8  result, valid only while a rsp*_valid is high.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states: IDLE, EXEC, RESP; encoding binary, 2 bits.
REQ-016 IDLE: with any reqN_valid high, grant one requester, assert its reqN_ready combinationally that same cycle, capture its a/b/op into operand registers, go to EXEC on the next edge.
REQ-017 Arbitration: only one valid -> grant it; both valid -> grant the requester not granted last (round-robin via 1-bit last_grant pointer, updated at each accept).
REQ-018 reqN_ready SHALL be high only in IDLE, only for the granted requester, and never for both in the same cycle.
REQ-019 A requester dropping valid before ready SHALL create no transaction.
REQ-020 alu_a/alu_b/alu_op SHALL be driven from the operand registers and held stable from the first EXEC cycle until the next accept.
REQ-021 EXEC lasts exactly ALU_LAT cycles (down-counter, 3 bits); on the last EXEC edge alu_out is captured into rsp_data and state goes to RESP.
REQ-022 RESP lasts exactly one cycle: rsp<grant>_valid high, other rsp valid low; then IDLE.
REQ-023 No response backpressure; requester must consume the strobe.
REQ-024 Request-to-response latency: ALU_LAT+1 cycles from the accept edge; throughput one operation per ALU_LAT+2 cycles.
REQ-025 Requests arriving during EXEC/RESP are ignored (ready low) and SHALL wait; no queuing.
REQ-026 rsp_data holds its last value outside RESP.

Reset
REQ-027 On rst high, immediately: state IDLE, busy 0, rsp0_valid 0, rsp1_valid 0, rsp_data 0, alu_a/alu_b/alu_op 0, counter 0, last_grant 1 (requester 0 wins first tie).
REQ-028 Reset during EXEC or RESP aborts the transaction; no response strobe SHALL follow.
REQ-029 reqN_ready SHALL be low while rst is high.

Structure
REQ-030 Shared package holds FSM state constants and opcode constants (OP_ADD=0, OP_MUL=1, OP_SUB=2, OP_AND=3).
REQ-031 One sub-module: rr_arb2 (two-input round-robin grant with last_grant register); FSM, counter and operand registers stay in alu_share_ctrl.
REQ-032 ALU is external; bench connects the team sequential ALU (registered output, ALU_LAT=1).

Verification
REQ-033 rst=1 with req0_valid=1, a=5,b=5 -> ready low, rsp valids 0, rsp_data 0, busy 0 for 2 cycles.
REQ-034 req0 only: a=7,b=3,op=1 -> req0_ready 1 cycle, rsp0_valid exactly ALU_LAT+1 cycles after accept, rsp_data=21, rsp1_valid stays 0.
REQ-035 Both valid continuously, req0 a=9,b=4,op=2 / req1 a=12,b=10,op=3 -> grants alternate 0,1,0,1; responses 5 and 8 on matching rsp strobes.
REQ-036 req1 raised during EXEC of req0 -> req1_ready low until IDLE, then accepted; no lost or duplicated response.
REQ-037 rst pulsed mid-EXEC of req0 a=15,b=15,op=0 -> no rsp0_valid; next request returns correct result (e.g. 2+3=5).
REQ-038 100 random ops per requester vs reference model (add, mul, sub mod 256, AND) -> all rsp_data match, strobe count equals accept count.
